// File: rtl/bus_arbiter2.sv
// bus_arbiter2 -- two-master to one-slave 16-bit bus arbiter.
//   master 0 : UART debug port, master 1 : DCPU core bus.
//   Grants are registered, a granted master owns the bus until the slave acks,
//   and a watchdog forces completion (ERR_DATA, sticky o_timeout) for a silent slave.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous
//   requests using a last-grant register; without it master 0 has fixed priority.
module bus_arbiter2 #(
   parameter int unsigned TIMEOUT  = 16,       // granted cycles without ack before forced completion (2..255)
   parameter logic [15:0] ERR_DATA = 16'hFFFF  // read data returned on a forced completion
) (
   input  logic        i_clk,
   input  logic        i_reset,
   // master 0 (UART)
   input  logic        i_m0_cs,
   input  logic        i_m0_we,
   input  logic [15:0] i_m0_addr,
   input  logic [15:0] i_m0_dat,
   output logic [15:0] o_m0_dat,
   output logic        o_m0_ack,
   // master 1 (CPU)
   input  logic        i_m1_cs,
   input  logic        i_m1_we,
   input  logic [15:0] i_m1_addr,
   input  logic [15:0] i_m1_dat,
   output logic [15:0] o_m1_dat,
   output logic        o_m1_ack,
   // shared slave bus
   output logic        o_s_cs,
   output logic        o_s_we,
   output logic [15:0] o_s_addr,
   output logic [15:0] o_s_dat,
   input  logic [15:0] i_s_dat,
   input  logic        i_s_ack,
   // status
   output logic [1:0]  o_grant,
   output logic        o_timeout
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GNT0 = 2'd1;
   localparam logic [1:0] ST_GNT1 = 2'd2;

   // Watchdog value at which a still-unacked transaction is forced to complete.
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  wd_cnt_q, wd_cnt_d;
   logic        timeout_q, timeout_d;

   logic        gnt0;       // master 0 owns the bus this cycle
   logic        gnt1;       // master 1 owns the bus this cycle
   logic        granted;    // some master owns the bus
   logic        wd_expire;  // watchdog forces completion this cycle
   logic        done;       // transaction completes this cycle (ack or forced)
   logic        pick_m0;    // IDLE arbitration result: master 0 wins
   logic [15:0] rd_dat;     // data returned to the granted master

   assign gnt0    = (state_q == ST_GNT0);
   assign gnt1    = (state_q == ST_GNT1);
   assign granted = gnt0 | gnt1;

   // A real slave ack in the expiry cycle wins: that is a normal completion.
   assign wd_expire = granted && !i_s_ack && (wd_cnt_q == WD_LAST);
   assign done      = granted && (i_s_ack || wd_expire);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q, last_d;  // 1 = master 1 was granted most recently

   // On a simultaneous request the master that did not win last time wins now.
   always_comb begin
      pick_m0 = i_m0_cs && (!i_m1_cs || last_q);
      last_d  = last_q;
      if (state_q == ST_IDLE && (i_m0_cs || i_m1_cs)) begin
         last_d = !pick_m0;
      end
   end

   // Last-grant register; starts as "master 1" so master 0 wins the first tie.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority: the UART master always wins a simultaneous request.
   assign pick_m0 = i_m0_cs;
`endif

   // Next-state, watchdog and sticky-timeout logic.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
      state_d   = state_q;
      wd_cnt_d  = 8'd0;
      timeout_d = timeout_q | wd_expire;

      case (state_q)
         ST_IDLE: begin
            if (pick_m0) begin
               state_d = ST_GNT0;
            end else if (i_m1_cs) begin
               state_d = ST_GNT1;
            end
         end
         ST_GNT0, ST_GNT1: begin
            if (done) begin
               state_d = ST_IDLE;  // one-cycle IDLE gap before the next grant
            end else begin
               wd_cnt_d = wd_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bus steering: the granted master's request passes straight to the slave,
   // the slave's response passes straight back; everything idle is driven low.
   always_comb begin
      o_s_cs   = granted;
      o_grant  = {gnt1, gnt0};
      o_s_we   = 1'b0;
      o_s_addr = 16'h0000;
      o_s_dat  = 16'h0000;

      if (gnt0) begin
         o_s_we   = i_m0_we;
         o_s_addr = i_m0_addr;
         o_s_dat  = i_m0_dat;
      end else if (gnt1) begin
         o_s_we   = i_m1_we;
         o_s_addr = i_m1_addr;
         o_s_dat  = i_m1_dat;
      end

      rd_dat   = wd_expire ? ERR_DATA : i_s_dat;
      o_m0_ack = gnt0 && done;
      o_m1_ack = gnt1 && done;
      o_m0_dat = gnt0 ? rd_dat : 16'h0000;
      o_m1_dat = gnt1 ? rd_dat : 16'h0000;
   end

   assign o_timeout = timeout_q;

   // State registers with synchronous reset; an aborted transaction gets no ack.
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      if (i_reset) begin
         state_q   <= ST_IDLE;
         wd_cnt_q  <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_bus_arbiter2.sv
// tb_bus_arbiter2 -- self-checking bench for bus_arbiter2.
// A transaction-level model predicts the service order of each burst of master
// requests and the response of every transaction; predictions go into a
// scoreboard queue that an independent monitor drains on every master ack.
module tb_bus_arbiter2;

   localparam int          TO       = 16;
   localparam logic [15:0] ERR_DATA = 16'hFFFF;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_m0_cs, i_m0_we;
   logic [15:0] i_m0_addr, i_m0_dat, o_m0_dat;
   logic        o_m0_ack;
   logic        i_m1_cs, i_m1_we;
   logic [15:0] i_m1_addr, i_m1_dat, o_m1_dat;
   logic        o_m1_ack;
   logic        o_s_cs, o_s_we;
   logic [15:0] o_s_addr, o_s_dat, i_s_dat;
   logic        i_s_ack;
   logic [1:0]  o_grant;
   logic        o_timeout;

   always #5 i_clk = ~i_clk;

   bus_arbiter2 #(.TIMEOUT(TO), .ERR_DATA(ERR_DATA)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_m0_cs(i_m0_cs), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr), .i_m0_dat(i_m0_dat),
      .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack),
      .i_m1_cs(i_m1_cs), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr), .i_m1_dat(i_m1_dat),
      .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack),
      .o_s_cs(o_s_cs), .o_s_we(o_s_we), .o_s_addr(o_s_addr), .o_s_dat(o_s_dat),
      .i_s_dat(i_s_dat), .i_s_ack(i_s_ack),
      .o_grant(o_grant), .o_timeout(o_timeout)
   );

   // One master transaction plus the response the model expects for it.
   typedef struct {
      int          m;            // requesting master
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdat;
      int          lat;          // granted cycle index at which the slave acks
      logic [15:0] exp_dat;      // expected o_mN_dat at ack
      logic        exp_to_flag;  // expected o_timeout during the ack cycle
      int          exp_cycle;    // expected granted cycle index of the ack
   } txn_t;

   txn_t        sb[$];           // scoreboard, in expected completion order
   txn_t        m0_txns[$];      // burst to be issued by master 0
   txn_t        m1_txns[$];      // burst to be issued by master 1
   int          slave_lat_q[$];  // slave ack latency per transaction, in service order
   logic [15:0] slave_mem[16];   // the slave's storage
   logic [15:0] ref_mem[16];     // the model's view of that storage
   logic        ref_timeout;     // model: has a forced completion happened since reset
   logic        ref_last;        // model: 1 = master 1 served most recently
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic txn_t mk_txn(input int m, input logic we, input logic [15:0] addr,
                                   input logic [15:0] wdat, input int lat);
      txn_t t;
      t.m = m; t.we = we; t.addr = addr; t.wdat = wdat; t.lat = lat;
      t.exp_dat = 16'h0000; t.exp_to_flag = 1'b0; t.exp_cycle = 0;
      return t;
   endfunction

   function automatic txn_t rand_txn(input int m);
      int r;
      int lat;
      r = int'($urandom_range(0, 9));
      if (r < 7)       lat = int'($urandom_range(0, 3));
      else if (r == 7) lat = TO - 1;                 // ack coincides with watchdog expiry
      else if (r == 8) lat = TO;                     // one cycle too late
      else             lat = TO + int'($urandom_range(1, 12));
      return mk_txn(m, 1'($urandom), 16'($urandom), 16'($urandom), lat);
   endfunction

   // Model: both masters present their bursts at once and each re-requests
   // immediately after every completion, so at each arbitration point every
   // master with work left is requesting.
   task automatic predict();
      txn_t a[$];
      txn_t b[$];
      txn_t t;
      bit   take0;
      a = m0_txns;
      b = m1_txns;
      while (a.size() + b.size() > 0) begin
         if (a.size() > 0 && b.size() > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
            take0 = ref_last;
`else
            take0 = 1'b1;
`endif
         end else begin
            take0 = (a.size() > 0);
         end
         if (take0) t = a.pop_front();
         else       t = b.pop_front();
         ref_last      = !take0;
         t.exp_to_flag = ref_timeout;
         if (t.lat >= TO) begin
            // Slave silent for the whole watchdog window: forced completion, no write.
            t.exp_dat   = ERR_DATA;
            t.exp_cycle = TO - 1;
            ref_timeout = 1'b1;
         end else begin
            t.exp_cycle = t.lat;
            if (t.we) begin
               ref_mem[t.addr[3:0]] = t.wdat;
               t.exp_dat = t.wdat;  // this slave echoes write data with its ack
            end else begin
               t.exp_dat = ref_mem[t.addr[3:0]];
            end
         end
         slave_lat_q.push_back(t.lat);
         sb.push_back(t);
      end
   endtask

   task automatic load_m0(input int idx);
      if (idx < m0_txns.size()) begin
         i_m0_cs = 1'b1; i_m0_we = m0_txns[idx].we;
         i_m0_addr = m0_txns[idx].addr; i_m0_dat = m0_txns[idx].wdat;
      end else begin
         i_m0_cs = 1'b0; i_m0_we = 1'($urandom);
         i_m0_addr = 16'($urandom); i_m0_dat = 16'($urandom);
      end
   endtask

   task automatic load_m1(input int idx);
      if (idx < m1_txns.size()) begin
         i_m1_cs = 1'b1; i_m1_we = m1_txns[idx].we;
         i_m1_addr = m1_txns[idx].addr; i_m1_dat = m1_txns[idx].wdat;
      end else begin
         i_m1_cs = 1'b0; i_m1_we = 1'($urandom);
         i_m1_addr = 16'($urandom); i_m1_dat = 16'($urandom);
      end
   endtask

   // Masters: present the bursts, move to the next transaction in the cycle after each ack.
   task automatic drive();
      int n0, n1, i0, i1, cyc, limit;
      bit got0, got1;
      n0 = m0_txns.size(); n1 = m1_txns.size();
      i0 = 0; i1 = 0; cyc = 0;
      limit = (TO + 4) * (n0 + n1) + 10;
      @(posedge i_clk); #1;
      load_m0(i0); load_m1(i1);
      while ((i0 < n0 || i1 < n1) && cyc < limit) begin
         @(negedge i_clk);
         got0 = o_m0_ack; got1 = o_m1_ack;
         @(posedge i_clk); #1;
         if (got0) begin i0++; load_m0(i0); end
         if (got1) begin i1++; load_m1(i1); end
         cyc++;
      end
      check("scenario_complete", 32'(i0 == n0 && i1 == n1), 32'd1);
      check("sb_drained", 32'(sb.size()), 32'd0);
      if (i0 != n0 || i1 != n1) begin
         i_m0_cs = 1'b0; i_m1_cs = 1'b0;
         sb.delete(); slave_lat_q.delete();
      end
   endtask

   // Slave: acks each transaction at its scheduled granted cycle, random noise otherwise
   // (including stray acks while the arbiter is idle).
   bit s_busy;
   int s_cnt, s_lat;
   initial begin
      i_s_ack = 1'b0; i_s_dat = 16'h0000; s_busy = 1'b0; s_cnt = 0; s_lat = 0;
      forever begin
         @(posedge i_clk); #2;
         if (o_s_cs) begin
            if (!s_busy) begin
               s_busy = 1'b1; s_cnt = 0;
               s_lat = (slave_lat_q.size() > 0) ? slave_lat_q.pop_front() : 1000;
            end
            if (s_cnt == s_lat) begin
               i_s_ack = 1'b1;
               if (o_s_we) begin
                  slave_mem[o_s_addr[3:0]] = o_s_dat;
                  i_s_dat = o_s_dat;
               end else begin
                  i_s_dat = slave_mem[o_s_addr[3:0]];
               end
            end else begin
               i_s_ack = 1'b0; i_s_dat = 16'($urandom);
            end
            s_cnt++;
         end else begin
            s_busy = 1'b0;
            i_s_ack = 1'($urandom);
            i_s_dat = 16'($urandom);
         end
      end
   end

   // Monitor: on every master ack, pop the next prediction and compare.
   txn_t e;
   bit   prev_cs;
   int   gcnt;
   initial begin
      prev_cs = 1'b0; gcnt = 0;
      forever begin
         @(negedge i_clk);
         if (o_s_cs) gcnt = prev_cs ? gcnt + 1 : 0;
         prev_cs = o_s_cs;
         if (o_m0_ack || o_m1_ack) begin
            if (sb.size() == 0) begin
               check("unexpected_ack", 32'({o_m1_ack, o_m0_ack}), 32'd0);
            end else begin
               e = sb.pop_front();
               check("ack_master", 32'({o_m1_ack, o_m0_ack}), (e.m == 0) ? 32'd1 : 32'd2);
               check("ack_grant", 32'(o_grant), (e.m == 0) ? 32'd1 : 32'd2);
               check("ack_data", 32'((e.m == 0) ? o_m0_dat : o_m1_dat), 32'(e.exp_dat));
               check("other_dat_zero", 32'((e.m == 0) ? o_m1_dat : o_m0_dat), 32'd0);
               check("s_addr", 32'(o_s_addr), 32'(e.addr));
               check("s_we", 32'(o_s_we), 32'(e.we));
               if (e.we) check("s_dat", 32'(o_s_dat), 32'(e.wdat));
               check("ack_cycle", 32'(gcnt), 32'(e.exp_cycle));
               check("timeout_flag", 32'(o_timeout), 32'(e.exp_to_flag));
            end
         end
      end
   end

   // Hard stop if something hangs outside the bounded loops.
   initial begin
      #500000;
      $display("FAIL global_time_limit: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 16; k++) begin slave_mem[k] = 16'h0000; ref_mem[k] = 16'h0000; end
      ref_timeout = 1'b0; ref_last = 1'b1;
      i_reset = 1'b1;
      i_m0_cs = 1'b1; i_m0_we = 1'b1; i_m0_addr = 16'h1111; i_m0_dat = 16'h2222;
      i_m1_cs = 1'b1; i_m1_we = 1'b1; i_m1_addr = 16'h3333; i_m1_dat = 16'h4444;

      // Reset state, with both masters requesting: reset must dominate.
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_s_cs", 32'(o_s_cs), 32'd0);
      check("rst_grant", 32'(o_grant), 32'd0);
      check("rst_acks", 32'({o_m1_ack, o_m0_ack}), 32'd0);
      check("rst_s_we", 32'(o_s_we), 32'd0);
      check("rst_s_addr", 32'(o_s_addr), 32'd0);
      check("rst_s_dat", 32'(o_s_dat), 32'd0);
      check("rst_timeout", 32'(o_timeout), 32'd0);
      @(posedge i_clk); #1;
      i_reset = 1'b0; load_m0(0); load_m1(0);  // queues empty: both idle

      // Single read from master 1 with a registered-ack slave: cycle-by-cycle latency.
      slave_mem[0] = 16'h1234; ref_mem[0] = 16'h1234;
      m0_txns.delete(); m1_txns.delete();
      m1_txns.push_back(mk_txn(1, 1'b0, 16'h0100, 16'h0000, 1));
      predict();
      @(posedge i_clk); #1;
      load_m1(0);                                           // cycle 0
      @(negedge i_clk);
      check("lat_c0_s_cs", 32'(o_s_cs), 32'd0);
      @(posedge i_clk); #1; @(negedge i_clk);               // cycle 1
      check("lat_c1_s_cs", 32'(o_s_cs), 32'd1);
      check("lat_c1_grant", 32'(o_grant), 32'd2);
      check("lat_c1_m1_ack", 32'(o_m1_ack), 32'd0);
      @(posedge i_clk); #1; @(negedge i_clk);               // cycle 2
      check("lat_c2_m1_ack", 32'(o_m1_ack), 32'd1);
      check("lat_c2_m1_dat", 32'(o_m1_dat), 32'h1234);
      check("lat_c2_grant", 32'(o_grant), 32'd2);
      check("lat_c2_m0_ack", 32'(o_m0_ack), 32'd0);
      @(posedge i_clk); #1;
      load_m1(1);                                           // cycle 3: drop cs
      @(negedge i_clk);
      check("lat_c3_s_cs", 32'(o_s_cs), 32'd0);
      check("lat_c3_grant", 32'(o_grant), 32'd0);
      check("lat_c3_acks", 32'({o_m1_ack, o_m0_ack}), 32'd0);

      // Write pass-through from master 0, then read it back through master 1.
      m0_txns.delete(); m1_txns.delete();
      m0_txns.push_back(mk_txn(0, 1'b1, 16'h00FF, 16'hBEEF, 2));
      predict(); drive();
      m0_txns.delete(); m1_txns.delete();
      m1_txns.push_back(mk_txn(1, 1'b0, 16'h00FF, 16'h0000, 0));
      predict(); drive();

      // Contention: master 0 keeps requesting while master 1 waits.
      m0_txns.delete(); m1_txns.delete();
      for (int k = 0; k < 3; k++) m0_txns.push_back(mk_txn(0, 1'b0, 16'(k), 16'h0000, 1));
      m1_txns.push_back(mk_txn(1, 1'b1, 16'h0007, 16'hA5A5, 1));
      predict(); drive();

      // Watchdog: ack exactly at the expiry cycle, then a silent slave, then a normal read.
      m0_txns.delete(); m1_txns.delete();
      m1_txns.push_back(mk_txn(1, 1'b0, 16'h0100, 16'h0000, TO - 1));
      m1_txns.push_back(mk_txn(1, 1'b0, 16'h0100, 16'h0000, TO + 20));
      m1_txns.push_back(mk_txn(1, 1'b0, 16'h0100, 16'h0000, 1));
      predict(); drive();
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("timeout_sticky", 32'(o_timeout), 32'(ref_timeout));

      // Reset in the middle of a master 0 transaction: bus released, no ack, flag cleared.
      slave_lat_q.push_back(100);
      m0_txns.delete(); m1_txns.delete();
      m0_txns.push_back(mk_txn(0, 1'b0, 16'h0042, 16'h0000, 100));
      @(posedge i_clk); #1;
      load_m0(0);
      @(posedge i_clk); #1; @(negedge i_clk);
      check("mid_rst_granted", 32'(o_grant), 32'd1);
      @(posedge i_clk); #1;
      i_reset = 1'b1; load_m0(1);
      @(posedge i_clk); #1; @(negedge i_clk);
      check("mid_rst_s_cs", 32'(o_s_cs), 32'd0);
      check("mid_rst_grant", 32'(o_grant), 32'd0);
      check("mid_rst_timeout", 32'(o_timeout), 32'd0);
      check("mid_rst_acks", 32'({o_m1_ack, o_m0_ack}), 32'd0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      ref_timeout = 1'b0; ref_last = 1'b1;
      slave_lat_q.delete();

      // Both masters requesting continuously right after reset.
      m0_txns.delete(); m1_txns.delete();
      for (int k = 0; k < 2; k++) begin
         m0_txns.push_back(mk_txn(0, 1'b1, 16'(16'h0010 + k), 16'(16'hC000 + k), 1));
         m1_txns.push_back(mk_txn(1, 1'b0, 16'(16'h0010 + k), 16'h0000, 0));
      end
      predict(); drive();

      // Randomized bursts.
      for (int s = 0; s < 40; s++) begin
         int n0, n1;
         m0_txns.delete(); m1_txns.delete();
         n0 = int'($urandom_range(0, 3));
         n1 = int'($urandom_range(0, 3));
         if (n0 + n1 == 0) n0 = 1;
         for (int k = 0; k < n0; k++) m0_txns.push_back(rand_txn(0));
         for (int k = 0; k < n1; k++) m1_txns.push_back(rand_txn(1));
         predict(); drive();
         repeat ($urandom_range(0, 2)) @(posedge i_clk);
      end

      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      check("final_timeout_flag", 32'(o_timeout), 32'(ref_timeout));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_arbiter2.md
Name: bus_arbiter2

Overview:
- Two-master to one-slave 16-bit bus arbiter. It sits directly downstream of the UART debug master port (master 0) and the DCPU core bus (master 1), and drives the shared memory/peripheral bus.
- The UART host can read and write memory while the CPU runs.
- Grants are registered and a transaction holds the bus until the slave acks.
- A watchdog completes any transaction the slave never acks.

Parameters:
- TIMEOUT, 16, cycles in a granted state without i_s_ack before forced completion; legal range 2..255.
- ERR_DATA, 16'hFFFF, read data returned to the master on a forced (timeout) completion.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_m0_cs  in  1  master 0 (UART) request; held until o_m0_ack
- i_m0_we  in  1  master 0 write enable
- i_m0_addr  in  16  master 0 address
- i_m0_dat  in  16  master 0 write data
- o_m0_dat  out  16  master 0 read data
- o_m0_ack  out  1  master 0 acknowledge, one cycle
- i_m1_cs, i_m1_we, i_m1_addr, i_m1_dat, o_m1_dat, o_m1_ack  same widths and meaning for master 1 (CPU)
- o_s_cs  out  1  slave select
- o_s_we  out  1  slave write enable
- o_s_addr  out  16  slave address
- o_s_dat  out  16  slave write data
- i_s_dat  in  16  slave read data
- i_s_ack  in  1  slave acknowledge
- o_grant  out  2  one-hot current grant: bit0 = m0, bit1 = m1
- o_timeout  out  1  sticky flag: a forced completion has occurred

Behaviour:
- State machine states: IDLE, GNT0, GNT1.
- Reset: state IDLE, watchdog counter 0, o_timeout 0. All outputs derived from IDLE are low:
  - o_s_cs = 0, o_grant = 0, o_m0_ack = 0, o_m1_ack = 0.
  - o_s_we = 0, o_s_addr = 0, o_s_dat = 0.
- A reset asserted mid-transaction returns to IDLE on the next edge. No ack is issued for the aborted transaction.
- IDLE transitions:
  - i_m0_cs -> GNT0.
  - Otherwise i_m1_cs -> GNT1.
  - Otherwise stay in IDLE.
  - Priority when both request: see Optional Feature.
- In GNTn:
  - o_s_cs = 1 and o_grant = one-hot n.
  - o_s_we, o_s_addr and o_s_dat are combinational copies of master n's inputs.
  - The non-granted master sees ack = 0 and keeps waiting.
- Ack path: o_mn_ack = i_s_ack while in GNTn (combinational, zero added latency). o_mn_dat = i_s_dat.
- The o_mn_dat output of a master not granted is 0.
- Normal completion: i_s_ack in GNTn -> IDLE on the next edge, giving a mandatory one-cycle IDLE gap between transactions.
- Masters must drop cs in the cycle after their ack. A cs still high in that IDLE cycle is treated as a new request.
- Latency: cs rises at cycle 0 in IDLE -> o_s_cs at cycle 1. For a registered-ack slave, ack arrives at cycle 2 and IDLE is reached at cycle 3.
- Watchdog:
  - The counter clears in IDLE and increments every cycle in GNTn without i_s_ack.
  - When the counter reaches TIMEOUT-1 without ack:
    - o_mn_ack is forced to 1 for that cycle and o_mn_dat = ERR_DATA.
    - o_timeout is set (sticky until reset).
    - The state goes to IDLE.
  - If i_s_ack arrives in that same cycle, it is a normal completion: slave data is returned and o_timeout is not set.
- i_s_ack while in IDLE is ignored.
- A master dropping cs before its ack while granted is a protocol error. The arbiter keeps the grant until ack or timeout and does not check for this.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Without the macro: fixed priority, master 0 (UART) always wins a simultaneous request in IDLE.
- With the macro:
  - A 1-bit last-grant register, reset to 1 (m1), records the master granted most recently.
  - On a simultaneous request in IDLE, the master not in last-grant wins.
  - With a single requester, that requester wins regardless of last-grant.

Test Plan:
- Single read: m1 cs, addr 16'h0100, slave acks one cycle after o_s_cs with 16'h1234 -> o_s_cs at cycle 1, o_m1_ack and o_m1_dat = 16'h1234 at cycle 2, o_grant = 2'b10 during cycles 1-2, IDLE at cycle 3, o_m0_ack never high.
- Write pass-through: m0 cs, we = 1, addr 16'h00FF, dat 16'hBEEF -> o_s_we = 1, o_s_addr = 16'h00FF, o_s_dat = 16'hBEEF while o_grant = 2'b01; a single o_m0_ack pulse.
- Contention, macro off: both cs high in IDLE for three back-to-back transactions -> order m0, m0, m0 while m0 keeps requesting; m1 is granted only after m0 stops, with the one-cycle IDLE gap each time.
- Contention, ARB_ROUND_ROBIN_EN: both request continuously -> grant order m0, m1, m0, m1 after reset.
- Timeout: TIMEOUT = 16, m1 read, slave never acks -> o_m1_ack at the 16th granted cycle with o_m1_dat = 16'hFFFF, o_timeout = 1 and staying 1. A following acked transaction completes normally.
- Reset mid-transaction: assert i_reset in GNT0 -> next cycle o_s_cs = 0, o_grant = 0, o_timeout = 0, no ack pulse.
